// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one dbus between the memory stage (port 0) and a secondary requester (port 1).
// Optional feature: define DBUS_ARB_ROUND_ROBIN_EN for round-robin arbitration of simultaneous requests.
`default_nettype none

package common;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;
endpackage

module dbus_arbiter
   import common::*;
(
   input  logic       clk,
   input  logic       rst,
   input  dbus_req_t  dreq0,
   output dbus_resp_t dresp0,
   input  dbus_req_t  dreq1,
   output dbus_resp_t dresp1,
   output dbus_req_t  dreq,
   input  dbus_resp_t dresp,
   output logic [1:0] owner
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN0  = 2'd1,
      ST_OWN1  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   state_e    state_q, state_d;
   logic      seen_q, seen_d;
   dbus_req_t lreq_q, lreq_d;
   dbus_req_t own_req;
   logic      pick1;
   logic      grant0, grant1;

`ifdef DBUS_ARB_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   // On a tie, the port that did not win last time goes first.
   assign pick1 = ~last_grant_q;
`else
   assign pick1 = 1'b0;
`endif

   assign grant0 = dreq0.valid & ~(dreq1.valid & pick1);
   assign grant1 = dreq1.valid & ~grant0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         seen_q  <= 1'b0;
         lreq_q  <= '0;
      end else begin
         state_q <= state_d;
         seen_q  <= seen_d;
         lreq_q  <= lreq_d;
      end
   end

   always_comb begin
      state_d = state_q;
      seen_d  = seen_q;
      lreq_d  = lreq_q;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      dreq    = '0;
      dresp0  = '0;
      dresp1  = '0;
      owner   = 2'b00;
      own_req = (state_q == ST_OWN1) ? dreq1 : dreq0;

      case (state_q)
         ST_IDLE: begin
            seen_d = 1'b0;
            if (grant0 || grant1) begin
               dreq   = grant1 ? dreq1 : dreq0;
               lreq_d = dreq;
               if (grant1) begin
                  dresp1 = dresp;
                  owner  = 2'b10;
               end else begin
                  dresp0 = dresp;
                  owner  = 2'b01;
               end
`ifdef DBUS_ARB_ROUND_ROBIN_EN
               last_grant_d = grant1;
`endif
               if (!dresp.data_ok) begin
                  state_d = grant1 ? ST_OWN1 : ST_OWN0;
                  seen_d  = dresp.addr_ok;
               end
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (own_req.valid) begin
               dreq = own_req;
               if (state_q == ST_OWN1) begin
                  dresp1 = dresp;
                  owner  = 2'b10;
               end else begin
                  dresp0 = dresp;
                  owner  = 2'b01;
               end
               if (dresp.data_ok) begin
                  state_d = ST_IDLE;
                  seen_d  = 1'b0;
               end else if (dresp.addr_ok) begin
                  seen_d = 1'b1;
               end
            end else if (seen_q) begin
               // Orphaned after address acceptance: keep the bus request alive until the data returns.
               dreq       = lreq_q;
               dreq.valid = 1'b1;
               if (dresp.data_ok) begin
                  state_d = ST_IDLE;
                  seen_d  = 1'b0;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               state_d = ST_IDLE;
               seen_d  = 1'b0;
            end
         end
         ST_DRAIN: begin
            dreq       = lreq_q;
            dreq.valid = 1'b1;
            if (dresp.data_ok) begin
               state_d = ST_IDLE;
               seen_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Reset blanks every output immediately, even while a requester still drives valid.
      if (rst) begin
         dreq   = '0;
         dresp0 = '0;
         dresp1 = '0;
         owner  = 2'b00;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed stimulus with a response scoreboard for dbus_arbiter.
`default_nettype none

module tb_dbus_arbiter;
   import common::*;

   logic       clk;
   logic       rst;
   dbus_req_t  dreq0, dreq1, dreq;
   dbus_resp_t dresp0, dresp1, dresp;
   logic [1:0] owner;

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   exp_t expq[$];
   int   checks;
   int   errors;

   localparam logic [31:0] ADDR_A = 32'h8000_0010;
   localparam logic [31:0] ADDR_B = 32'h9000_0020;
   localparam logic [31:0] ADDR_C = 32'hA000_0040;

   dbus_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .dreq0  (dreq0),
      .dresp0 (dresp0),
      .dreq1  (dreq1),
      .dresp1 (dresp1),
      .dreq   (dreq),
      .dresp  (dresp),
      .owner  (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic dbus_req_t mkreq(input logic [31:0] a, input logic [31:0] d);
      dbus_req_t r;
      r.valid  = 1'b1;
      r.addr   = a;
      r.size   = 3'd2;
      r.strobe = 4'hF;
      r.data   = d;
      return r;
   endfunction

   function automatic dbus_resp_t mkresp(input logic aok, input logic dok, input logic [31:0] d);
      dbus_resp_t r;
      r.addr_ok = aok;
      r.data_ok = dok;
      r.data    = d;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic expect_resp(input int port, input logic [31:0] d);
      exp_t e;
      e.port = port;
      e.data = d;
      expq.push_back(e);
   endtask

   // Monitor: masking on every cycle, and a scoreboard pop on every delivered data_ok.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (owner != 2'b01 && dresp0 !== '0) begin
            errors++;
            $display("FAIL mask0: dresp0=%h owner=%b expected zero response", dresp0, owner);
         end
         checks++;
         if (owner != 2'b10 && dresp1 !== '0) begin
            errors++;
            $display("FAIL mask1: dresp1=%h owner=%b expected zero response", dresp1, owner);
         end
         if (dresp0.data_ok || dresp1.data_ok) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: dresp0=%h dresp1=%h expected no response", dresp0, dresp1);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("resp_port", dresp1.data_ok ? 32'd1 : 32'd0, 32'(e.port));
               chk("resp_data", dresp1.data_ok ? dresp1.data : dresp0.data, e.data);
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      dreq0  = mkreq(ADDR_A, 32'h1);
      dreq1  = '0;
      dresp  = mkresp(1'b1, 1'b1, 32'hFFFF_FFFF);

      // Reset: outputs zero despite an active request and bus response.
      cyc();
      mid();
      chk("rst_dreq_valid", 32'(dreq.valid), 32'd0);
      chk("rst_dreq_addr", dreq.addr, 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_dresp0", 32'(dresp0.data_ok), 32'd0);
      cyc();
      rst   = 1'b0;
      dreq0 = '0;
      dresp = '0;

      // Single port-0 load: addr_ok at cycle 1, data_ok at cycle 3.
      cyc();
      dreq0 = mkreq(ADDR_A, 32'h0);
      mid();
      chk("t1_owner_c0", 32'(owner), 32'h1);
      chk("t1_dreq_addr", dreq.addr, ADDR_A);
      chk("t1_dreq_valid", 32'(dreq.valid), 32'd1);
      cyc();
      dresp = mkresp(1'b1, 1'b0, 32'h0);
      mid();
      chk("t1_addr_ok", 32'(dresp0.addr_ok), 32'd1);
      cyc();
      dresp = '0;
      mid();
      chk("t1_owner_c2", 32'(owner), 32'h1);
      cyc();
      dresp = mkresp(1'b0, 1'b1, 32'hDEAD_BEEF);
      expect_resp(0, 32'hDEAD_BEEF);
      mid();
      // Cycle 4: arbiter must be idle again, so a lone port-1 request is granted at once.
      cyc();
      dreq0 = '0;
      dreq1 = mkreq(ADDR_B, 32'h0);
      dresp = '0;
      mid();
      chk("t1_idle_c4_owner", 32'(owner), 32'h2);
      chk("t1_idle_c4_addr", dreq.addr, ADDR_B);
      cyc();
      dresp = mkresp(1'b1, 1'b1, 32'h1111_2222);
      expect_resp(1, 32'h1111_2222);
      mid();
      cyc();
      dreq1 = '0;
      dresp = '0;
      mid();
      chk("t1_quiet", 32'(dreq.valid), 32'd0);

      // Simultaneous requests: port 0 first, port 1 the cycle after port 0's data_ok.
      cyc();
      dreq0 = mkreq(ADDR_A, 32'h0);
      dreq1 = mkreq(ADDR_B, 32'h0);
      mid();
      chk("t2_owner_first", 32'(owner), 32'h1);
      chk("t2_dresp1_pending", 32'(dresp1), 32'd0);
      cyc();
      dresp = mkresp(1'b1, 1'b1, 32'h0000_00A0);
      expect_resp(0, 32'h0000_00A0);
      mid();
      cyc();
      dreq0 = '0;
      dresp = '0;
      mid();
      chk("t2_owner_second", 32'(owner), 32'h2);
      chk("t2_dreq_addr", dreq.addr, ADDR_B);
      cyc();
      dresp = mkresp(1'b1, 1'b1, 32'h0000_00B1);
      expect_resp(1, 32'h0000_00B1);
      mid();
      cyc();
      dreq1 = '0;
      dresp = '0;
      mid();

      // Both ports continuously valid for four transactions.
      for (int i = 0; i < 4; i++) begin
         int ep;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
         ep = i % 2;
`else
         ep = 0;
`endif
         cyc();
         dreq0 = mkreq(ADDR_A, 32'h0);
         dreq1 = mkreq(ADDR_B, 32'h0);
         dresp = '0;
         mid();
         chk("t3_owner", 32'(owner), (ep == 1) ? 32'h2 : 32'h1);
         chk("t3_addr", dreq.addr, (ep == 1) ? ADDR_B : ADDR_A);
         cyc();
         dresp = mkresp(1'b1, 1'b1, 32'hC000_0000 + 32'(i));
         expect_resp(ep, 32'hC000_0000 + 32'(i));
         mid();
      end
      cyc();
      dreq0 = '0;
      dreq1 = '0;
      dresp = '0;
      mid();

      // Orphan: port 1 drops valid after addr_ok; the transaction drains, then port 0 goes.
      cyc();
      dreq1 = mkreq(ADDR_C, 32'h0);
      mid();
      chk("t4_owner_grant", 32'(owner), 32'h2);
      cyc();
      dresp = mkresp(1'b1, 1'b0, 32'h0);
      mid();
      cyc();
      dreq1 = '0;
      dreq0 = mkreq(ADDR_A, 32'h0);
      dresp = '0;
      mid();
      chk("t4_drop_valid", 32'(dreq.valid), 32'd1);
      chk("t4_drop_addr", dreq.addr, ADDR_C);
      chk("t4_drop_owner", 32'(owner), 32'd0);
      cyc();
      dresp = mkresp(1'b0, 1'b1, 32'h5555_5555);
      mid();
      chk("t4_drain_valid", 32'(dreq.valid), 32'd1);
      chk("t4_drain_addr", dreq.addr, ADDR_C);
      cyc();
      dresp = '0;
      mid();
      chk("t4_next_owner", 32'(owner), 32'h1);
      chk("t4_next_addr", dreq.addr, ADDR_A);
      cyc();
      dresp = mkresp(1'b1, 1'b1, 32'h0000_0D0D);
      expect_resp(0, 32'h0000_0D0D);
      mid();
      cyc();
      dreq0 = '0;
      dresp = '0;
      mid();

      // data_ok in the grant cycle: FSM stays idle, so port 1 is granted the very next cycle.
      cyc();
      dreq0 = mkreq(ADDR_A, 32'h0);
      dresp = mkresp(1'b1, 1'b1, 32'h1234_5678);
      expect_resp(0, 32'h1234_5678);
      mid();
      chk("t5_owner_grant", 32'(owner), 32'h1);
      cyc();
      dreq0 = '0;
      dreq1 = mkreq(ADDR_B, 32'h0);
      dresp = '0;
      mid();
      chk("t5_owner_after", 32'(owner), 32'h2);
      cyc();
      dresp = mkresp(1'b1, 1'b1, 32'h8765_4321);
      expect_resp(1, 32'h8765_4321);
      mid();
      cyc();
      dreq1 = '0;
      dresp = '0;
      mid();

      // Reset in the middle of an OWN1 transaction.
      cyc();
      dreq1 = mkreq(ADDR_B, 32'h0);
      mid();
      chk("t6_owner_pre", 32'(owner), 32'h2);
      cyc();
      dresp = mkresp(1'b1, 1'b0, 32'h0);
      mid();
      cyc();
      dresp = '0;
      rst   = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(dreq.valid), 32'd0);
      chk("t6_rst_owner", 32'(owner), 32'd0);
      cyc();
      rst   = 1'b0;
      dreq1 = '0;
      dreq0 = mkreq(ADDR_A, 32'h0);
      mid();
      chk("t6_post_owner", 32'(owner), 32'h1);
      chk("t6_post_addr", dreq.addr, ADDR_A);
      cyc();
      dresp = mkresp(1'b1, 1'b1, 32'h0BAD_F00D);
      expect_resp(0, 32'h0BAD_F00D);
      mid();
      cyc();
      dreq0 = '0;
      dresp = '0;
      mid();
      cyc();
      mid();

      chk("scoreboard_empty", 32'(expq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-requester arbiter that shares the single data bus (`dbus_req_t`/`dbus_resp_t`) between the memory stage (port 0) and a secondary requester (port 1, e.g. a page-table walker or debug/DMA agent). It sits between the memory-stage access logic and the core's dbus output. It grants one requester per transaction and holds the grant until `data_ok`. It routes the response back only to the owner, and drains orphaned transactions safely.

## Interface
Parameters:
- none; all widths come from `common::dbus_req_t` / `common::dbus_resp_t`.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `dreq0`  in  dbus_req_t  memory-stage request (valid, addr, size, strobe, data).
- `dresp0`  out  dbus_resp_t  response to port 0.
- `dreq1`  in  dbus_req_t  secondary request.
- `dresp1`  out  dbus_resp_t  response to port 1.
- `dreq`  out  dbus_req_t  request to dbus.
- `dresp`  in  dbus_resp_t  response from dbus (addr_ok, data_ok, data).
- `owner`  out  2  one-hot current grant; 0 when idle or draining.

## Operation
- States: IDLE, OWN0, OWN1, DRAIN.
- IDLE:
  - Winner chosen combinationally from `dreq0.valid`/`dreq1.valid`.
  - The winner's request is forwarded on `dreq` in the same cycle (zero-latency grant).
  - If `dresp.data_ok` arrives in that cycle, the transaction completes and the FSM stays IDLE.
  - Otherwise the FSM moves to OWN0/OWN1.
- OWNx:
  - `dreq` = `dreqx`; `drespx` = `dresp`; the other port's response is all zeros.
  - On `data_ok`, go to IDLE. The next grant is evaluated in the following cycle, so there are no back-to-back grants from the same edge.
- Orphan: if the owner drops `valid` while in OWNx before `data_ok`, and `addr_ok` was already seen for that transaction:
  - go to DRAIN; `dreq.valid` is held at 1 with the latched request fields;
  - wait for `data_ok`, discard the data, then go to IDLE.
  - If `addr_ok` has not been seen, go straight to IDLE and issue nothing further.
- Latched copy: a copy of the granted request (addr, size, strobe, data) is registered at grant time for DRAIN use. An `addr_ok_seen` flag is set on `addr_ok` and cleared on leaving OWN/DRAIN.
- Response masking: a non-owner always sees `addr_ok=0`, `data_ok=0`, `data=0`.
- Priority (macro off): fixed, port 0 wins.
- `owner` = 2'b01 in OWN0 or during an IDLE grant to 0; 2'b10 likewise for port 1; 2'b00 otherwise.

## Timing
- Reset values:
  - state IDLE; `last_grant` = 1; `addr_ok_seen` = 0; latched request = 0.
  - `dreq` = all zeros; `dresp0`/`dresp1` = all zeros; `owner` = 0.
- Reset mid-transaction aborts immediately. Outputs go to zero asynchronously; no drain is attempted.
- Latency: request to `dreq` is 0 cycles; `dresp` to owner `drespx` is 0 cycles (combinational pass-through).
- Minimum of one IDLE cycle between two granted transactions, unless `data_ok` arrived in the grant cycle.
- Simultaneous valid in IDLE: arbitration rule applies; the loser stays pending with `drespx` zero.
- Requesters must hold `dreqx` stable until `data_ok`; only a `valid` drop is tolerated, via the orphan rule.

## Configuration
- `DBUS_ARB_ROUND_ROBIN_EN` defined:
  - simultaneous requests in IDLE are granted to the port not in `last_grant`;
  - `last_grant` updates on every grant.
  - A single requester is always granted regardless of `last_grant`.
- Undefined: fixed priority, port 0 always wins, and `last_grant` is unused.

## Test plan
- Single port-0 load, addr 0x8000_0010, `addr_ok` at cycle 1, `data_ok` at cycle 3 with data 0xDEAD_BEEF -> `dresp0.data`=0xDEAD_BEEF at cycle 3, `dresp1` all zero throughout, FSM back to IDLE at cycle 4.
- Both ports valid in the same cycle, fixed priority -> port 0 served first, port 1 granted in the cycle after port 0's `data_ok`.
- With `DBUS_ARB_ROUND_ROBIN_EN`, both ports continuously valid for 4 transactions -> grant order 0,1,0,1.
- Port 1 drops valid after `addr_ok` but before `data_ok` -> `dreq.valid` stays 1 with the latched addr, `data_ok` is consumed with no response on `dresp1`, then IDLE; a pending port-0 request is granted the next cycle.
- `data_ok` in the same cycle as the IDLE grant -> `dresp0.data_ok`=1 that cycle, the FSM never leaves IDLE, and `owner`=2'b01 for exactly that cycle.
- `rst` asserted mid-OWN1 -> `dreq.valid`=0 and `owner`=0 immediately; after release, the first request is granted normally.
